asg_seq_ctrl: RTL and testbench

Segment sequencer for one arbitrary-signal-generator channel. Holds a small table of segment descriptors (pointer step, amplitude, DC offset, cycle count, inter-segment gap), and on start loads each descriptor into the channel configuration. It issues a software trigger, waits for the channel burst to finish, then advances to the next segment. Sits between the ASG register bank and the channel's `set_*`/`trig_sw_i` inputs in the DAC clock domain.

---
 rtl/asg_pkg.sv | 27 ++
 rtl/asg_seq_desc_ram.sv | 66 ++++++
 rtl/asg_seq_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_asg_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asg_pkg.sv
// asg_pkg: shared definitions for the ASG segment sequencer.
//   - descriptor field selects used by the table write port
//   - sequencer state encoding
//   - ARM settle length and WAIT_BUSY timeout length
package asg_pkg;

    // Descriptor field selects (desc_fld_i)
    localparam logic [1:0] FLD_STEP  = 2'd0;   // pointer step, right-aligned
    localparam logic [1:0] FLD_AMPDC = 2'd1;   // {amp[29:16], dc[13:0]}
    localparam logic [1:0] FLD_NCYC  = 2'd2;   // cycle count [15:0]
    localparam logic [1:0] FLD_GAP   = 2'd3;   // inter-segment gap [31:0]

    // Cycles spent in ARM after the descriptor lands on set_*_o
    localparam int SETTLE   = 2;
    // Cycles WAIT_BUSY tolerates without ch_busy_i before flagging an error
    localparam int BUSY_TMO = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_GAP
    } asg_state_e;

endpackage : asg_pkg

// File: rtl/asg_seq_desc_ram.sv
// asg_seq_desc_ram: NSEG-entry segment descriptor table.
// Each entry holds step, amplitude, DC offset, cycle count and gap. Writes
// update one field of one entry per cycle; reads are combinational by index
// so a same-cycle write to the entry being read returns the old contents.
// Ports:
//   dac_clk_i, dac_rst_i   clock, asynchronous active-high reset (clears table)
//   we_i, addr_i, fld_i    field write strobe, entry index, field select
//   wdata_i                right-aligned field data
//   rd_addr_i              read index
//   rd_step_o .. rd_gap_o  fields of entry rd_addr_i
module asg_seq_desc_ram
    import asg_pkg::*;
#(
    parameter int RSZ  = 14,
    parameter int NSEG = 8,
    parameter int AW   = 3
) (
    input  logic              dac_clk_i,
    input  logic              dac_rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [1:0]        fld_i,
    input  logic [31:0]       wdata_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [RSZ+15:0]   rd_step_o,
    output logic [13:0]       rd_amp_o,
    output logic [13:0]       rd_dc_o,
    output logic [15:0]       rd_ncyc_o,
    output logic [31:0]       rd_gap_o
);

    logic [RSZ+15:0] step_q [NSEG];
    logic [13:0]     amp_q  [NSEG];
    logic [13:0]     dc_q   [NSEG];
    logic [15:0]     ncyc_q [NSEG];
    logic [31:0]     gap_q  [NSEG];

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            for (int i = 0; i < NSEG; i++) begin
                step_q[i] <= '0;
                amp_q[i]  <= '0;
                dc_q[i]   <= '0;
                ncyc_q[i] <= '0;
                gap_q[i]  <= '0;
            end
        end else if (we_i) begin
            case (fld_i)
                FLD_STEP:  step_q[addr_i] <= wdata_i[RSZ+15:0];
                FLD_AMPDC: begin
                    amp_q[addr_i] <= wdata_i[29:16];
                    dc_q[addr_i]  <= wdata_i[13:0];
                end
                FLD_NCYC:  ncyc_q[addr_i] <= wdata_i[15:0];
                default:   gap_q[addr_i]  <= wdata_i;
            endcase
        end
    end

    assign rd_step_o = step_q[rd_addr_i];
    assign rd_amp_o  = amp_q[rd_addr_i];
    assign rd_dc_o   = dc_q[rd_addr_i];
    assign rd_ncyc_o = ncyc_q[rd_addr_i];
    assign rd_gap_o  = gap_q[rd_addr_i];

endmodule : asg_seq_desc_ram

// File: rtl/asg_seq_ctrl.sv
// asg_seq_ctrl: segment sequencer for one ASG channel.
// Walks a table of segment descriptors: loads each one onto the channel
// configuration, fires a software trigger, waits for the burst to end, waits
// the programmed gap, then moves to the next segment (optionally looping).
// Ports:
//   dac_clk_i, dac_rst_i            clock, asynchronous active-high reset
//   desc_we_i/addr_i/fld_i/wdata_i  descriptor table field write
//   seq_len_i, seq_loop_i           segment count (1..NSEG), loop enable
//   start_i, stop_i                 start / abort pulses (stop wins)
//   ch_busy_i                       channel burst active
//   set_step_o/amp_o/dc_o/ncyc_o    channel configuration
//   trig_sw_o, set_rst_o, done_o    one-cycle trigger / channel reset / end
//   seg_idx_o, running_o, err_o     current segment, active, sticky error
module asg_seq_ctrl
    import asg_pkg::*;
#(
    parameter int RSZ  = 14,
    parameter int NSEG = 8,
    parameter int AW   = 3
) (
    input  logic              dac_clk_i,
    input  logic              dac_rst_i,
    input  logic              desc_we_i,
    input  logic [AW-1:0]     desc_addr_i,
    input  logic [1:0]        desc_fld_i,
    input  logic [31:0]       desc_wdata_i,
    input  logic [AW:0]       seq_len_i,
    input  logic              seq_loop_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              ch_busy_i,
    output logic [RSZ+15:0]   set_step_o,
    output logic [13:0]       set_amp_o,
    output logic [13:0]       set_dc_o,
    output logic [15:0]       set_ncyc_o,
    output logic              trig_sw_o,
    output logic              set_rst_o,
    output logic [AW-1:0]     seg_idx_o,
    output logic              running_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [AW:0] SEG_MAX = (AW+1)'(NSEG);

    asg_state_e      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW:0]     len_q, len_d;
    logic [1:0]      settle_q, settle_d;
    logic [3:0]      tmo_q, tmo_d;
    logic [31:0]     gap_q, gap_d;
    logic [RSZ+15:0] step_q, step_d;
    logic [13:0]     amp_q, amp_d;
    logic [13:0]     dc_q, dc_d;
    logic [15:0]     ncyc_q, ncyc_d;
    logic            trig_q, trig_d;
    logic            set_rst_q, set_rst_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            running_q, running_d;

    logic [RSZ+15:0] rd_step;
    logic [13:0]     rd_amp;
    logic [13:0]     rd_dc;
    logic [15:0]     rd_ncyc;
    logic [31:0]     rd_gap;

    logic            len_ok;
    logic            last_seg;

    asg_seq_desc_ram #(
        .RSZ  (RSZ),
        .NSEG (NSEG),
        .AW   (AW)
    ) u_desc_ram (
        .dac_clk_i (dac_clk_i),
        .dac_rst_i (dac_rst_i),
        .we_i      (desc_we_i),
        .addr_i    (desc_addr_i),
        .fld_i     (desc_fld_i),
        .wdata_i   (desc_wdata_i),
        .rd_addr_i (idx_q),
        .rd_step_o (rd_step),
        .rd_amp_o  (rd_amp),
        .rd_dc_o   (rd_dc),
        .rd_ncyc_o (rd_ncyc),
        .rd_gap_o  (rd_gap)
    );

    assign len_ok   = (seq_len_i != '0) && (seq_len_i <= SEG_MAX);
    // Segment count is captured at start so a register-bank rewrite of
    // seq_len_i mid-sequence cannot leave idx past the end.
    assign last_seg = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        step_d    = step_q;
        amp_d     = amp_q;
        dc_d      = dc_q;
        ncyc_d    = ncyc_q;
        err_d     = err_q;
        trig_d    = 1'b0;
        set_rst_d = 1'b0;
        done_d    = 1'b0;

        if (stop_i && (state_q != ST_IDLE)) begin
            // Abort overrides every other transition in the same cycle.
            state_d   = ST_IDLE;
            set_rst_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_ok) begin
                            err_d   = 1'b0;
                            idx_d   = '0;
                            len_d   = seq_len_i;
                            state_d = ST_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    step_d   = rd_step;
                    amp_d    = rd_amp;
                    dc_d     = rd_dc;
                    ncyc_d   = rd_ncyc;
                    settle_d = 2'(SETTLE);
                    state_d  = ST_ARM;
                end
                ST_ARM: begin
                    settle_d = settle_q - 2'd1;
                    // Counter reaches 0 on this edge: trigger leaves with it.
                    if (settle_q <= 2'd1) begin
                        settle_d = '0;
                        trig_d   = 1'b1;
                        tmo_d    = '0;
                        state_d  = ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (ch_busy_i) begin
                        state_d = ST_RUN;
                    end else if (tmo_q == 4'(BUSY_TMO - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (!ch_busy_i) begin
                        gap_d   = rd_gap;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0) begin
                        if (!last_seg) begin
                            idx_d   = idx_q + AW'(1);
                            state_d = ST_LOAD;
                        end else if (seq_loop_i) begin
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q - 32'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        running_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            step_q    <= '0;
            amp_q     <= '0;
            dc_q      <= '0;
            ncyc_q    <= '0;
            trig_q    <= 1'b0;
            set_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            step_q    <= step_d;
            amp_q     <= amp_d;
            dc_q      <= dc_d;
            ncyc_q    <= ncyc_d;
            trig_q    <= trig_d;
            set_rst_q <= set_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
            running_q <= running_d;
        end
    end

    assign set_step_o = step_q;
    assign set_amp_o  = amp_q;
    assign set_dc_o   = dc_q;
    assign set_ncyc_o = ncyc_q;
    assign trig_sw_o  = trig_q;
    assign set_rst_o  = set_rst_q;
    assign seg_idx_o  = idx_q;
    assign running_o  = running_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule : asg_seq_ctrl

// File: tb/tb_asg_seq_ctrl.sv
// Directed bench for asg_seq_ctrl. Cycle n is the interval after the n-th
// rising edge; inputs are driven and outputs sampled 1 ns after the edge.
module tb_asg_seq_ctrl;

    localparam int RSZ  = 14;
    localparam int NSEG = 8;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            desc_we = 1'b0;
    logic [AW-1:0]   desc_addr = '0;
    logic [1:0]      desc_fld = '0;
    logic [31:0]     desc_wdata = '0;
    logic [AW:0]     seq_len = 4'd1;
    logic            seq_loop = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            busy = 1'b0;
    logic [RSZ+15:0] set_step;
    logic [13:0]     set_amp;
    logic [13:0]     set_dc;
    logic [15:0]     set_ncyc;
    logic            trig_sw;
    logic            set_rst;
    logic [AW-1:0]   seg_idx;
    logic            running;
    logic            done;
    logic            err;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    asg_seq_ctrl #(.RSZ(RSZ), .NSEG(NSEG), .AW(AW)) dut (
        .dac_clk_i    (clk),
        .dac_rst_i    (rst),
        .desc_we_i    (desc_we),
        .desc_addr_i  (desc_addr),
        .desc_fld_i   (desc_fld),
        .desc_wdata_i (desc_wdata),
        .seq_len_i    (seq_len),
        .seq_loop_i   (seq_loop),
        .start_i      (start),
        .stop_i       (stop),
        .ch_busy_i    (busy),
        .set_step_o   (set_step),
        .set_amp_o    (set_amp),
        .set_dc_o     (set_dc),
        .set_ncyc_o   (set_ncyc),
        .trig_sw_o    (trig_sw),
        .set_rst_o    (set_rst),
        .seg_idx_o    (seg_idx),
        .running_o    (running),
        .done_o       (done),
        .err_o        (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int idx, input logic [1:0] fld, input logic [31:0] data);
        desc_we    = 1'b1;
        desc_addr  = idx[AW-1:0];
        desc_fld   = fld;
        desc_wdata = data;
        tick();
        desc_we    = 1'b0;
    endtask

    // Start driven in the current cycle; returns one cycle later (LOAD).
    task automatic pulse_start(input int len, input bit loop_en);
        seq_len  = len[AW:0];
        seq_loop = loop_en;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // which: 0 trig_sw, 1 done, 2 err. at = cycle seen, -1 if budget expired.
    task automatic wait_sig(input int which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (at < 0) begin
                if ((which == 0 && trig_sw) || (which == 1 && done) || (which == 2 && err))
                    at = cyc;
                else
                    tick();
            end
        end
    endtask

    // Busy high from the current cycle for b cycles; t_fall = first low cycle.
    task automatic run_busy(input int b, output int t_fall);
        busy = 1'b1;
        ticks(b);
        busy = 1'b0;
        t_fall = cyc;
    endtask

    initial begin
        int s, t1, t2, tf, td, te, at;

        // ---- reset ----
        ticks(3);
        chk("rst_step", set_step, 0);
        chk("rst_running", running, 0);
        chk("rst_trig", trig_sw, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_running", running, 0);
        $display("phase reset cyc=%0d", cyc);

        // ---- two segments, no loop ----
        wr(0, 2'd0, 32'h0001_0000);
        wr(0, 2'd1, 32'h1000_0020);
        wr(0, 2'd2, 32'd3);
        wr(0, 2'd3, 32'd10);
        wr(1, 2'd0, 32'h0002_0000);
        wr(1, 2'd1, 32'h0800_3FFF);
        wr(1, 2'd2, 32'd5);
        wr(1, 2'd3, 32'd10);
        s = cyc;
        pulse_start(2, 1'b0);
        chk("s1_running", running, 1);
        chk("s1_idx0", seg_idx, 0);
        tick();
        chk("s1_step0", set_step, 32'h0001_0000);
        chk("s1_amp0", set_amp, 14'h1000);
        chk("s1_dc0", set_dc, 14'h0020);
        chk("s1_ncyc0", set_ncyc, 3);
        tick();
        chk("s1_trig_early", trig_sw, 0);
        wait_sig(0, 10, t1);
        chk("s1_trig_lat", t1 - s, 4);
        run_busy(20, tf);
        wait_sig(0, 60, t2);
        chk("s1_trig2_time", t2, tf + 15);
        chk("s1_trig_spacing", t2 - t1, 35);
        chk("s1_idx1", seg_idx, 1);
        chk("s1_step1", set_step, 32'h0002_0000);
        chk("s1_amp1", set_amp, 14'h0800);
        chk("s1_dc1", set_dc, 14'h3FFF);
        chk("s1_ncyc1", set_ncyc, 5);
        run_busy(20, tf);
        wait_sig(1, 40, td);
        chk("s1_done_time", td, tf + 12);
        chk("s1_running_end", running, 0);
        tick();
        chk("s1_done_pulse", done, 0);
        $display("phase two_seg trig1=%0d trig2=%0d done=%0d", t1, t2, td);

        // ---- loop, one segment, gap 0, then stop ----
        wr(0, 2'd3, 32'd0);
        s = cyc;
        pulse_start(1, 1'b1);
        wait_sig(0, 10, t1);
        chk("s2_trig_lat", t1 - s, 4);
        run_busy(6, tf);
        wait_sig(0, 20, t2);
        chk("s2_trig2_time", t2, tf + 5);
        chk("s2_period", t2 - t1, 11);
        chk("s2_idx", seg_idx, 0);
        busy = 1'b1;
        ticks(3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        busy = 1'b0;
        chk("s2_set_rst", set_rst, 1);
        chk("s2_stop_running", running, 0);
        chk("s2_stop_done", done, 0);
        tick();
        chk("s2_set_rst_pulse", set_rst, 0);
        wait_sig(1, 20, at);
        chk("s2_no_done", at, -1);
        $display("phase loop_stop trig1=%0d trig2=%0d", t1, t2);

        // ---- busy timeout ----
        pulse_start(1, 1'b0);
        wait_sig(0, 10, t1);
        wait_sig(2, 30, te);
        chk("s3_err_time", te, t1 + 16);
        chk("s3_err_idle", running, 0);
        pulse_start(1, 1'b0);
        chk("s3_err_clear", err, 0);
        chk("s3_restart", running, 1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("s3_stop_arm", set_rst, 1);
        tick();
        $display("phase timeout trig=%0d err=%0d", t1, te);

        // ---- bad lengths, start ignored while running ----
        pulse_start(9, 1'b0);
        chk("s4_len9_err", err, 1);
        chk("s4_len9_idle", running, 0);
        pulse_start(1, 1'b0);
        chk("s4_err_clear", err, 0);
        wait_sig(0, 10, t1);
        busy = 1'b1;
        ticks(2);
        seq_len  = 4'd2;
        seq_loop = 1'b1;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        seq_len  = 4'd1;
        seq_loop = 1'b0;
        chk("s4_ign_running", running, 1);
        chk("s4_ign_idx", seg_idx, 0);
        ticks(2);
        busy = 1'b0;
        tf = cyc;
        wait_sig(1, 20, td);
        chk("s4_done_time", td, tf + 2);
        tick();
        pulse_start(0, 1'b0);
        chk("s4_len0_err", err, 1);
        chk("s4_len0_idle", running, 0);
        wait_sig(0, 8, at);
        chk("s4_len0_no_trig", at, -1);
        $display("phase bad_len done=%0d", td);

        // ---- async reset mid-gap ----
        wr(0, 2'd3, 32'd50);
        pulse_start(1, 1'b0);
        wait_sig(0, 10, t1);
        run_busy(3, tf);
        ticks(5);
        chk("s5_pre_running", running, 1);
        chk("s5_pre_step", set_step, 32'h0001_0000);
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_step", set_step, 0);
        chk("s5_async_amp", set_amp, 0);
        chk("s5_async_running", running, 0);
        chk("s5_async_err", err, 0);
        ticks(2);
        rst = 1'b0;
        ticks(3);
        chk("s5_idle_running", running, 0);
        chk("s5_idle_trig", trig_sw, 0);
        pulse_start(1, 1'b0);
        tick();
        chk("s5_tbl_step", set_step, 0);
        chk("s5_tbl_amp", set_amp, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        $display("phase reset_gap cyc=%0d", cyc);

        // ---- live descriptor rewrite, stop+start collision ----
        wr(0, 2'd0, 32'h0001_0000);
        wr(0, 2'd2, 32'd3);
        wr(0, 2'd3, 32'd2);
        wr(1, 2'd1, 32'h0111_0005);
        pulse_start(2, 1'b0);
        wait_sig(0, 10, t1);
        busy = 1'b1;
        wr(1, 2'd1, 32'h1234_0005);
        ticks(3);
        busy = 1'b0;
        tf = cyc;
        wait_sig(0, 20, t2);
        chk("s6_trig2_time", t2, tf + 7);
        chk("s6_idx1", seg_idx, 1);
        chk("s6_new_amp", set_amp, 14'h1234);
        busy = 1'b1;
        ticks(2);
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        chk("s6_collide_rst", set_rst, 1);
        chk("s6_collide_idle", running, 0);
        tick();
        chk("s6_collide_stay", running, 0);
        busy = 1'b0;
        wait_sig(0, 8, at);
        chk("s6_no_trig", at, -1);
        $display("phase rewrite_collide trig2=%0d", t2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_asg_seq_ctrl
